addsub_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 8-bit adder/subtractor. Accepts add/subtract requests from two clients over valid/ready handshakes, grants round-robin, and drives the shared arithmetic unit's operands. It returns the result with zero/overflow flags and the winning requester's ID. It sits between the datapath clients and the single combinational adder instance.

---
 rtl/addsub_arbiter_pkg.sv | 25 ++
 rtl/addsub_arbiter_rr_arbiter2.sv | 33 +++
 rtl/addsub_arbiter.sv | 139 +++++++++++++
 tb/tb_addsub_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the two-requester add/subtract arbiter: FSM states,
// op encoding and signed range helpers.
package addsub_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEF_WIDTH = 8;

  // Two's-complement range limits for a w-bit value, right-aligned in 64 bits.
  function automatic logic [63:0] signed_min(input int w);
    return 64'(1) << (w - 1);
  endfunction

  function automatic logic [63:0] signed_max(input int w);
    return (64'(1) << (w - 1)) - 64'(1);
  endfunction

endpackage

// File: rtl/addsub_arbiter_rr_arbiter2.sv
// Two-input round-robin grant. last_id records the requester served most
// recently; on contention the other requester wins.
module rr_arbiter2
  import addsub_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last_id;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_id <= 1'b1;
    end else if (upd) begin
      last_id <= upd_id;
    end
  end

  // req1 wins when it is alone, or when both request and req0 was served last.
  always_comb begin
    gnt_id = req[1] & (~req[0] | ~last_id);
    gnt    = {req[1] & gnt_id, req[0] & ~gnt_id};
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin sequencer for a shared combinational add/subtract unit.
// Optional output saturation on signed overflow: define ADDSUB_ARB_SAT_EN.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  input  logic [WIDTH-1:0] au_c,
  input  logic             au_zero,
  input  logic             au_overflow
);

  localparam logic [WIDTH-1:0] SMIN = WIDTH'(signed_min(WIDTH));
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(signed_max(WIDTH));

  state_t           state;
  logic             op_q;
  logic             id_q;
  logic [WIDTH-1:0] b_q;

  logic [1:0]       gnt;
  logic             gnt_id;
  logic             arb_en;
  logic             accept;

  logic             w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_b_eff;

  logic             sub_min;
  logic             ovf;
  logic [WIDTH-1:0] res;
  logic             zero;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .upd    (state == ST_EXEC),
    .upd_id (id_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Ready is only offered in IDLE and never while reset is asserted.
  assign arb_en     = rst_n && (state == ST_IDLE);
  assign req0_ready = arb_en & gnt[0];
  assign req1_ready = arb_en & gnt[1];
  assign accept     = req0_ready | req1_ready;

  assign w_op    = gnt_id ? req1_op : req0_op;
  assign w_a     = gnt_id ? req1_a  : req0_a;
  assign w_b     = gnt_id ? req1_b  : req0_b;
  assign w_b_eff = (w_op == OP_SUB) ? (~w_b + WIDTH'(1)) : w_b;

  // Negating the most-negative b wraps to itself, so the adder's overflow flag
  // is meaningless there: a - SMIN overflows exactly when a is non-negative.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sub_min = (op_q == OP_SUB) && (b_q == SMIN);
    ovf     = sub_min ? ~au_a[WIDTH-1] : au_overflow;
    res     = au_c;
    zero    = au_zero;
`ifdef ADDSUB_ARB_SAT_EN
    // On overflow the true result carries the sign of a.
    if (ovf) begin
      res  = au_a[WIDTH-1] ? SMIN : SMAX;
      zero = (res == '0);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      op_q         <= OP_ADD;
      id_q         <= 1'b0;
      b_q          <= '0;
      au_a         <= '0;
      au_b         <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= w_op;
            id_q  <= gnt_id;
            b_q   <= w_b;
            au_a  <= w_a;
            au_b  <= w_b_eff;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result   <= res;
          rsp_zero     <= zero;
          rsp_overflow <= ovf;
          rsp_id       <= id_q;
          rsp_valid    <= 1'b1;
          state        <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a behavioural model of the shared adder.
module tb_addsub_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_op;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_op;
  logic [7:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_overflow;
  logic [7:0] rsp_result;
  logic [7:0] au_a, au_b, au_c;
  logic       au_zero, au_overflow;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Shared adder model
  assign au_c        = au_a + au_b;
  assign au_zero     = (au_c == 8'h00);
  assign au_overflow = (au_a[7] == au_b[7]) && (au_c[7] != au_a[7]);

  addsub_arbiter #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_op      (req0_op),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_op      (req1_op),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .au_a         (au_a),
    .au_b         (au_b),
    .au_c         (au_c),
    .au_zero      (au_zero),
    .au_overflow  (au_overflow)
  );

`ifdef ADDSUB_ARB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Present a request and wait (bounded) for its ready; returns in EXEC.
  task automatic do_accept(input string tag, input logic id, input logic op,
                           input logic [7:0] a, input logic [7:0] b);
    logic seen = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = id ? req1_ready : req0_ready;
    end
    check({tag, "_ready"}, 32'(seen), 32'(1));
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Called in EXEC with rsp_ready = 1; returns in the following IDLE cycle.
  task automatic expect_rsp(input string tag, input logic id, input logic [7:0] res,
                            input logic ovf, input logic zero);
    @(negedge clk);
    check({tag, "_exec_valid"}, 32'(rsp_valid), 32'(0));
    check({tag, "_exec_rdy"}, 32'({req0_ready, req1_ready}), 32'(0));
    @(posedge clk); @(negedge clk);
    check({tag, "_valid"}, 32'(rsp_valid), 32'(1));
    check({tag, "_result"}, 32'(rsp_result), 32'(res));
    check({tag, "_id"}, 32'(rsp_id), 32'(id));
    check({tag, "_ovf"}, 32'(rsp_overflow), 32'(ovf));
    check({tag, "_zero"}, 32'(rsp_zero), 32'(zero));
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 1'b0; req0_a = 8'd1; req0_b = 8'd1;
    req1_valid = 1'b0; req1_op = 1'b0; req1_a = 8'd0; req1_b = 8'd0;

    // Reset values; req0 is already waiting but must not see ready in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp", 32'({rsp_id, rsp_zero, rsp_overflow, rsp_result}), 32'(0));
    check("rst_au", 32'({au_a, au_b}), 32'(0));
    check("rst_ready", 32'({req0_ready, req1_ready}), 32'(0));

    // Basic add 1+1, accepted in the first cycle out of reset
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("add_ready", 32'({req0_ready, req1_ready}), 32'(2'b10));
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    check("add_au", 32'({au_a, au_b}), 32'(16'h0101));
    check("add_exec_valid", 32'(rsp_valid), 32'(0));
    @(posedge clk); @(negedge clk);
    check("add_valid", 32'(rsp_valid), 32'(1));
    check("add_result", 32'(rsp_result), 32'(8'h02));
    check("add_flags", 32'({rsp_id, rsp_zero, rsp_overflow}), 32'(0));
    @(posedge clk); @(negedge clk);
    check("add_done", 32'(rsp_valid), 32'(0));

    // Signed overflow 100+100
    do_accept("ovf", 1'b1, 1'b0, 8'd100, 8'd100);
    check("ovf_au_b", 32'(au_b), 32'(8'd100));
    expect_rsp("ovf", 1'b1, SAT ? 8'h7F : 8'hC8, 1'b1, 1'b0);

    // Zero result and subtract operand negation
    do_accept("zero", 1'b0, 1'b1, 8'd5, 8'd5);
    check("zero_au_b", 32'(au_b), 32'(8'hFB));
    expect_rsp("zero", 1'b0, 8'h00, 1'b0, 1'b1);

    // Subtract of most-negative b: both directions of the flag fix-up
    do_accept("smin0", 1'b0, 1'b1, 8'h00, 8'h80);
    expect_rsp("smin0", 1'b0, SAT ? 8'h7F : 8'h80, 1'b1, 1'b0);
    do_accept("sminff", 1'b0, 1'b1, 8'hFF, 8'h80);
    expect_rsp("sminff", 1'b0, 8'h7F, 1'b0, 1'b0);

    // Contention straight out of reset: req0 first, then alternation
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = 1'b1; req0_a = 8'd10; req0_b = 8'd5;
    req1_valid = 1'b1; req1_op = 1'b0; req1_a = 8'hFD; req1_b = 8'hFC;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("cont1_ready", 32'({req0_ready, req1_ready}), 32'(2'b10));
    @(posedge clk); #1;
    req0_op = 1'b0; req0_a = 8'd2; req0_b = 8'd3;   // req0 re-requests at once
    expect_rsp("cont1", 1'b0, 8'h05, 1'b0, 1'b0);
    @(negedge clk);
    check("cont2_ready", 32'({req0_ready, req1_ready}), 32'(2'b01));
    @(posedge clk); #1;
    req1_a = 8'd1; req1_b = 8'd2;                   // req1 re-requests at once
    expect_rsp("cont2", 1'b1, 8'hF9, 1'b0, 1'b0);
    @(negedge clk);
    check("cont3_ready", 32'({req0_ready, req1_ready}), 32'(2'b10));
    @(posedge clk); #1 req0_valid = 1'b0;
    expect_rsp("cont3", 1'b0, 8'h05, 1'b0, 1'b0);
    @(negedge clk);
    check("cont4_ready", 32'({req0_ready, req1_ready}), 32'(2'b01));
    @(posedge clk); #1 req1_valid = 1'b0;
    expect_rsp("cont4", 1'b1, 8'h03, 1'b0, 1'b0);

    // Backpressure: response held for 5 cycles while req1 waits
    rsp_ready = 1'b0;
    do_accept("bp", 1'b0, 1'b0, 8'h7F, 8'h01);
    req1_valid = 1'b1; req1_op = 1'b0; req1_a = 8'd3; req1_b = 8'd4;
    @(negedge clk);
    check("bp_exec_valid", 32'(rsp_valid), 32'(0));
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      check("bp_hold_rsp", 32'({rsp_valid, rsp_id, rsp_overflow, rsp_zero, rsp_result}),
            32'({1'b1, 1'b0, 1'b1, 1'b0, SAT ? 8'h7F : 8'h80}));
      check("bp_hold_rdy", 32'({req0_ready, req1_ready}), 32'(0));
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rdy", 32'({req0_ready, req1_ready}), 32'(0));
    @(posedge clk); @(negedge clk);
    check("bp_idle_valid", 32'(rsp_valid), 32'(0));
    check("bp_next_ready", 32'(req1_ready), 32'(1));
    @(posedge clk); #1 req1_valid = 1'b0;
    expect_rsp("bp_next", 1'b1, 8'h07, 1'b0, 1'b0);

    // Reset during EXEC abandons the request
    do_accept("mid", 1'b0, 1'b0, 8'd1, 8'd2);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mid_valid", 32'(rsp_valid), 32'(0));
    check("mid_rsp", 32'({rsp_id, rsp_zero, rsp_overflow, rsp_result}), 32'(0));
    check("mid_au", 32'({au_a, au_b}), 32'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("mid_no_rsp", 32'(rsp_valid), 32'(0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
